// File: rtl/parking_sensor_pattern_gen_if.sv
// Command/status bundle between a car-emulation requester and the beam-pattern generator.
// The master issues start/dir/phase_len/abort; the slave drives beams a/b and status.
interface parking_sensor_pattern_gen_if #(
    parameter int LEN_W = 24
);
    logic             start;
    logic             dir;
    logic [LEN_W-1:0] phase_len;
    logic             abort;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             reject;
    logic [7:0]       occupancy;

    modport master (
        output start, dir, phase_len, abort,
        input  a, b, busy, done, aborted, reject, occupancy
    );

    modport slave (
        input  start, dir, phase_len, abort,
        output a, b, busy, done, aborted, reject, occupancy
    );
endinterface

// File: rtl/parking_sensor_pattern_gen.sv
// Car emulator: walks beams a/b through the Gray-coded enter/exit pattern with a
// programmable per-phase dwell and optional back-out, and keeps lot occupancy.
module parking_sensor_pattern_gen #(
    parameter logic [7:0] CAPACITY   = 8'd200,
    parameter int         LEN_W      = 24,
    parameter int         GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    parking_sensor_pattern_gen_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_GAP} state_t;

    state_t           r_state, w_next;
    logic [LEN_W-1:0] r_cnt, r_len_m1, w_len_m1, w_cnt_next;
    logic [7:0]       r_occ, w_occ_next;
    logic             r_dir, r_rev, r_a, r_b, r_done, r_aborted, r_reject;
    logic             w_in_p, w_rev, w_ok, w_accept, w_refuse, w_dwell_end;
    logic             w_dir, w_a, w_b, w_finish;

    assign w_in_p      = (r_state == S_P1) || (r_state == S_P2) || (r_state == S_P3);
    // An abort seen in the final dwell cycle must already steer this transition.
    assign w_rev       = r_rev | (w_in_p & bus.abort);
    assign w_ok        = bus.dir ? (r_occ != 8'd0) : (r_occ < CAPACITY);
    assign w_accept    = (r_state == S_IDLE) & bus.start & w_ok;
    assign w_refuse    = (r_state == S_IDLE) & bus.start & ~w_ok;
    assign w_dwell_end = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len_m1  <= '0;
            r_occ     <= 8'd0;
            r_dir     <= 1'b0;
            r_rev     <= 1'b0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_reject  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_occ     <= w_occ_next;
            r_a       <= w_a;
            r_b       <= w_b;
            r_done    <= w_finish;
            r_aborted <= w_finish & r_rev;
            r_reject  <= w_refuse;
            if (w_accept) begin
                r_dir    <= bus.dir;
                r_len_m1 <= w_len_m1;
                r_rev    <= 1'b0;
            end else if (w_in_p && bus.abort) begin
                r_rev    <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_next = S_P1;
            S_P1:    if (w_dwell_end) w_next = w_rev ? S_GAP : S_P2;
            S_P2:    if (w_dwell_end) w_next = w_rev ? S_P1  : S_P3;
            S_P3:    if (w_dwell_end) w_next = w_rev ? S_P2  : S_GAP;
            S_GAP:   if (w_dwell_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        // Direction and length come straight from the request on the accept cycle.
        w_dir    = (r_state == S_IDLE) ? bus.dir : r_dir;
        w_len_m1 = r_len_m1;
        if (r_state == S_IDLE)
            w_len_m1 = (bus.phase_len == '0) ? '0 : bus.phase_len - LEN_W'(1);

        w_a = 1'b0;
        w_b = 1'b0;
        case (w_next)
            S_P1:    begin w_a = ~w_dir; w_b =  w_dir; end
            S_P2:    begin w_a = 1'b1;   w_b = 1'b1;   end
            S_P3:    begin w_a =  w_dir; w_b = ~w_dir; end
            default: begin w_a = 1'b0;   w_b = 1'b0;   end
        endcase

        w_cnt_next = r_cnt;
        if (w_next != r_state) begin
            if (w_next == S_GAP)       w_cnt_next = LEN_W'(GAP_CYCLES - 1);
            else if (w_next == S_IDLE) w_cnt_next = '0;
            else                       w_cnt_next = w_len_m1;
        end else if (!w_dwell_end) begin
            w_cnt_next = r_cnt - LEN_W'(1);
        end

        w_finish   = (r_state == S_GAP) && (w_next == S_IDLE);
        w_occ_next = r_occ;
        if (w_finish && !r_rev)
            w_occ_next = r_dir ? r_occ - 8'd1 : r_occ + 8'd1;
    end

    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.aborted   = r_aborted;
    assign bus.reject    = r_reject;
    assign bus.occupancy = r_occ;
endmodule

// File: tb/tb_parking_sensor_pattern_gen.sv
// Directed bench for the beam-pattern generator (CAPACITY=3 so the full-lot path is reachable).
module tb_parking_sensor_pattern_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    parking_sensor_pattern_gen_if #(.LEN_W(24)) bus_if ();

    parking_sensor_pattern_gen #(.CAPACITY(8'd3), .LEN_W(24), .GAP_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first P1 cycle.
    task automatic start_seq(input logic d, input int len);
        bus_if.start     = 1'b1;
        bus_if.dir       = d;
        bus_if.phase_len = 24'(len);
        @(negedge clk);
        bus_if.start     = 1'b0;
    endtask

    task automatic expect_ab(input string tag, input logic [1:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_ab"}, {30'd0, bus_if.a, bus_if.b}, {30'd0, pat});
            check({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd1);
            @(negedge clk);
        end
    endtask

    task automatic expect_done(input string tag, input logic ab, input int occ);
        check({tag, "_done"}, {31'd0, bus_if.done}, 32'd1);
        check({tag, "_aborted"}, {31'd0, bus_if.aborted}, {31'd0, ab});
        check({tag, "_busy0"}, {31'd0, bus_if.busy}, 32'd0);
        check({tag, "_idle_ab"}, {30'd0, bus_if.a, bus_if.b}, 32'd0);
        check({tag, "_occ"}, {24'd0, bus_if.occupancy}, 32'(occ));
    endtask

    task automatic expect_reject(input string tag);
        check({tag, "_reject"}, {31'd0, bus_if.reject}, 32'd1);
        check({tag, "_rej_busy"}, {31'd0, bus_if.busy}, 32'd0);
        check({tag, "_rej_ab"}, {30'd0, bus_if.a, bus_if.b}, 32'd0);
    endtask

    // Full single-cycle-dwell sequence: enter 10,11,01 / exit 01,11,10, then 00 x2, then done.
    task automatic short_seq(input string tag, input logic d, input int occ);
        start_seq(d, 1);
        expect_ab(tag, d ? 2'b01 : 2'b10, 1);
        expect_ab(tag, 2'b11, 1);
        expect_ab(tag, d ? 2'b10 : 2'b01, 1);
        expect_ab(tag, 2'b00, 2);
        expect_done(tag, 1'b0, occ);
        @(negedge clk);
    endtask

    initial begin
        bus_if.start     = 1'b0;
        bus_if.dir       = 1'b0;
        bus_if.phase_len = '0;
        bus_if.abort     = 1'b0;
        #3;
        check("rst_ab", {30'd0, bus_if.a, bus_if.b}, 32'd0);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_done", {31'd0, bus_if.done}, 32'd0);
        check("rst_aborted", {31'd0, bus_if.aborted}, 32'd0);
        check("rst_reject", {31'd0, bus_if.reject}, 32'd0);
        check("rst_occ", {24'd0, bus_if.occupancy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Enter, dwell 3: busy for 3+3+3+2 = 11 cycles.
        start_seq(1'b0, 3);
        expect_ab("ent3", 2'b10, 3);
        expect_ab("ent3", 2'b11, 3);
        expect_ab("ent3", 2'b01, 3);
        expect_ab("ent3", 2'b00, 2);
        expect_done("ent3", 1'b0, 1);
        @(negedge clk);
        check("ent3_done_pulse", {31'd0, bus_if.done}, 32'd0);

        // Exit with phase_len 0 behaves as dwell 1.
        start_seq(1'b1, 0);
        expect_ab("ext0", 2'b01, 1);
        expect_ab("ext0", 2'b11, 1);
        expect_ab("ext0", 2'b10, 1);
        expect_ab("ext0", 2'b00, 2);
        expect_done("ext0", 1'b0, 0);
        @(negedge clk);

        // Exit from an empty lot is refused.
        start_seq(1'b1, 1);
        expect_reject("ext_empty");
        @(negedge clk);
        check("ext_empty_pulse", {31'd0, bus_if.reject}, 32'd0);
        check("ext_empty_idle", {31'd0, bus_if.busy}, 32'd0);

        // Enter dwell 4, abort in second P2 cycle: back out through P1.
        start_seq(1'b0, 4);
        expect_ab("abt", 2'b10, 4);
        expect_ab("abt", 2'b11, 1);
        bus_if.abort = 1'b1;
        expect_ab("abt", 2'b11, 1);
        bus_if.abort = 1'b0;
        expect_ab("abt", 2'b11, 2);
        expect_ab("abt", 2'b10, 4);
        expect_ab("abt", 2'b00, 2);
        expect_done("abt", 1'b1, 0);
        @(negedge clk);

        // Fill the lot to capacity 3, then a fourth enter is refused.
        short_seq("fill1", 1'b0, 1);
        short_seq("fill2", 1'b0, 2);
        short_seq("fill3", 1'b0, 3);
        start_seq(1'b0, 1);
        expect_reject("full");
        @(negedge clk);
        short_seq("drain", 1'b1, 2);
        short_seq("refill", 1'b0, 3);

        // Reset in the middle of an exit's P2 clears everything asynchronously.
        start_seq(1'b1, 3);
        expect_ab("rstmid", 2'b01, 3);
        expect_ab("rstmid", 2'b11, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_ab", {30'd0, bus_if.a, bus_if.b}, 32'd0);
        check("rstmid_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rstmid_occ", {24'd0, bus_if.occupancy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        short_seq("post_rst", 1'b0, 1);

        // start held high: each new sequence launches from the done cycle.
        bus_if.start     = 1'b1;
        bus_if.dir       = 1'b0;
        bus_if.phase_len = 24'd1;
        @(negedge clk);
        for (int k = 2; k <= 3; k++) begin
            expect_ab("b2b", 2'b10, 1);
            expect_ab("b2b", 2'b11, 1);
            expect_ab("b2b", 2'b01, 1);
            expect_ab("b2b", 2'b00, 2);
            expect_done("b2b", 1'b0, k);
            @(negedge clk);
        end
        expect_reject("b2b_full");
        bus_if.start = 1'b0;
        @(negedge clk);
        check("b2b_rej_pulse", {31'd0, bus_if.reject}, 32'd0);
        check("b2b_occ_final", {24'd0, bus_if.occupancy}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
